seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_core.sv | 48 ++++
 rtl/seq_det_ctrl.sv | 121 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial sequence detector.
package seq_det_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_det_core.sv
// History shifter, fill counter and pattern comparator for the sequence detector.
// The match flag is combinational and includes the bit being sampled this edge,
// so the controller can register y and bump the count on that same edge.
module seq_det_core #(
    parameter int PAT_W  = 8,
    parameter int LEN_W  = 3,
    parameter int FILL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              x,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [LEN_W-1:0]  len,
    input  logic              overlap,
    output logic              match
);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_nxt;
    logic [PAT_W-1:0]  mask;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [FILL_W-1:0] plen;

    // Look-ahead view of history/fill including the incoming bit, and the compare.
    always_comb begin
        plen     = FILL_W'(len) + FILL_W'(1);
        hist_nxt = {hist[PAT_W-2:0], x};
        fill_nxt = (fill >= plen) ? plen : fill + FILL_W'(1);
        // plen == PAT_W shifts every one out, leaving a full mask after inversion
        mask     = ~({PAT_W{1'b1}} << plen);
        match    = shift_en && (fill_nxt == plen) && (((hist_nxt ^ pattern) & mask) == '0);
    end

    // Detection state only advances on qualified bits; start or reset wipes it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_nxt;
            fill <= (match && !overlap) ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial sequence detector: IDLE/RUN/DONE FSM,
// configuration shadow registers, saturating match counter and registered flags.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [$clog2(PAT_W)-1:0] cfg_len,
    input  logic                     cfg_overlap,
    input  logic [CNT_W-1:0]         cfg_target,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     X_valid,
    input  logic                     X,
    output logic                     y,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int LEN_W  = $clog2(PAT_W);
    localparam int FILL_W = $clog2(PAT_W + 1);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q;
    logic             shift_en;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] cnt_inc;

    // Bits are consumed only while running; a stop edge discards the bit.
    always_comb begin
        shift_en = (state == ST_RUN) && X_valid && !stop;
        clr      = (state != ST_RUN) && start && !stop;
        cnt_inc  = (match_cnt == {CNT_W{1'b1}}) ? match_cnt : match_cnt + CNT_W'(1);
    end

    seq_det_core #(
        .PAT_W  (PAT_W),
        .LEN_W  (LEN_W),
        .FILL_W (FILL_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .x        (X),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .match    (match)
    );

    // FSM, configuration capture, match counting and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b1;
            tgt_q     <= '0;
            match_cnt <= '0;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            y       <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (state == ST_RUN) begin
                    cfg_err <= 1'b1;
                end else begin
                    pat_q <= cfg_pattern;
                    len_q <= cfg_len;
                    ovl_q <= cfg_overlap;
                    tgt_q <= cfg_target;
                end
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !stop) begin
                        state     <= ST_RUN;
                        match_cnt <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (match) begin
                        match_cnt <= cnt_inc;
                        y         <= 1'b1;
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: the driver runs a bit-list reference model
// and queues the expected outputs; a negedge monitor pops and compares.
module tb_seq_det_ctrl;

    localparam int PAT_W   = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DONE  = 2;

    logic             clk = 1'b0;
    logic             rst, cfg_we, cfg_overlap, start, stop, X_valid, X;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             y, busy, done, cfg_err;
    logic [CNT_W-1:0] match_cnt;

    always #5 clk = ~clk;

    seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .stop        (stop),
        .X_valid     (X_valid),
        .X           (X),
        .y           (y),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    typedef struct {
        bit y;
        int cnt;
        bit busy;
        bit done;
        bit err;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // reference model: every accepted bit since start, plus the index where the
    // current non-overlapping window begins
    int       mode = M_IDLE;
    bit [7:0] m_pat = 0;
    int       m_len = 1;
    bit       m_ov  = 1;
    int       m_tgt = 0;
    bit       bits[$];
    int       seg = 0;
    int       cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit we, input bit st, input bit sp,
                       input bit xv, input bit xb);
        exp_t e;
        int   n;
        bit   hit;
        rst = r; cfg_we = we; start = st; stop = sp; X_valid = xv; X = xb;
        e.y = 0; e.err = 0;
        if (r) begin
            mode = M_IDLE; cnt = 0; m_pat = 0; m_len = 1; m_ov = 1; m_tgt = 0;
            bits.delete(); seg = 0;
        end else begin
            if (we) begin
                if (mode == M_RUN) e.err = 1;
                else begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len) + 1;
                    m_ov = cfg_overlap; m_tgt = int'(cfg_target);
                end
            end
            if (mode != M_RUN) begin
                if (st && !sp) begin
                    mode = M_RUN; cnt = 0; bits.delete(); seg = 0;
                end
            end else if (sp) begin
                mode = M_IDLE;
            end else if (xv) begin
                bits.push_back(xb);
                n   = bits.size();
                hit = (n - seg) >= m_len;
                for (int k = 0; k < m_len; k++)
                    if (hit && bits[n-1-k] != m_pat[k]) hit = 0;
                if (hit) begin
                    e.y = 1;
                    if (cnt < CNT_MAX) cnt++;
                    if (!m_ov) seg = n;
                    if (m_tgt != 0 && cnt == m_tgt) mode = M_DONE;
                end
            end
        end
        e.cnt  = cnt;
        e.busy = (mode == M_RUN);
        e.done = (mode == M_DONE);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_set(input bit [7:0] pat, input int len, input bit ov, input int tgt);
        cfg_pattern = pat; cfg_len = LEN_W'(len - 1); cfg_overlap = ov; cfg_target = CNT_W'(tgt);
        cyc(0, 1, 0, 0, 0, 0);
    endtask

    task automatic send(input bit b);
        cyc(0, 0, 0, 0, 1, b);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // monitor: every cycle the DUT presents a full output set
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("y",         32'(y),         32'(e.y));
                chk("match_cnt", 32'(match_cnt), 32'(e.cnt));
                chk("busy",      32'(busy),      32'(e.busy));
                chk("done",      32'(done),      32'(e.done));
                chk("cfg_err",   32'(cfg_err),   32'(e.err));
            end
        end
    end

    initial begin
        bit s1[7];
        bit [7:0] rp;
        s1 = '{1, 1, 0, 1, 1, 0, 1};
        rst = 1; cfg_we = 0; start = 0; stop = 0; X_valid = 0; X = 0;
        cfg_pattern = 0; cfg_len = 0; cfg_overlap = 1; cfg_target = 0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle_cyc();

        // 1101 overlapping, unlimited
        cfg_set(8'b1101, 4, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        foreach (s1[i]) send(s1[i]);
        idle_cyc();
        @(negedge clk);
        chk("s1_cnt", 32'(match_cnt), 32'd2);

        // same stream, non-overlapping
        cyc(0, 0, 0, 1, 0, 0);
        cfg_set(8'b1101, 4, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        foreach (s1[i]) send(s1[i]);
        idle_cyc();
        @(negedge clk);
        chk("s2_cnt", 32'(match_cnt), 32'd1);

        // 11, target 2: done after third bit, fourth ignored
        cyc(0, 0, 0, 1, 0, 0);
        cfg_set(8'b11, 2, 1, 2);
        cyc(0, 0, 1, 0, 0, 0);
        repeat (4) send(1);
        idle_cyc();
        @(negedge clk);
        chk("s3_cnt", 32'(match_cnt), 32'd2);
        chk("s3_done", 32'(done), 32'd1);

        // 1101 with valid gaps, then a rejected config write mid-run
        cfg_set(8'b1101, 4, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        send(1); idle_cyc(); send(1); idle_cyc(); idle_cyc();
        send(0); idle_cyc(); send(1); idle_cyc();
        @(negedge clk);
        chk("s4_cnt", 32'(match_cnt), 32'd1);
        cfg_set(8'b0, 1, 0, 1);
        send(1); send(1); send(0); send(1);
        idle_cyc();
        @(negedge clk);
        chk("s4_keep", 32'(match_cnt), 32'd2);

        // reset mid-run, then start+stop together from IDLE
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        send(1); send(1); send(0);
        cyc(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s5_cnt", 32'(match_cnt), 32'd0);
        chk("s5_y", 32'(y), 32'd0);
        cyc(0, 0, 1, 1, 0, 0);
        @(negedge clk);
        chk("s5_busy", 32'(busy), 32'd0);

        // randomized runs
        for (int run = 0; run < 40; run++) begin
            if (mode == M_RUN) cyc(0, 0, 0, 1, 0, 0);
            rp = 8'($urandom);
            cfg_set(rp, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
            cyc(0, 0, 1, 0, 0, 0);
            for (int c = 0; c < 60; c++) begin
                bit r, we, st, sp;
                r  = ($urandom_range(0, 299) == 0);
                we = ($urandom_range(0, 39) == 0);
                st = ($urandom_range(0, 49) == 0);
                sp = ($urandom_range(0, 79) == 0);
                if (we) begin
                    cfg_pattern = 8'($urandom);
                    cfg_len     = LEN_W'($urandom_range(0, 3));
                    cfg_overlap = 1'($urandom_range(0, 1));
                    cfg_target  = CNT_W'($urandom_range(0, 3));
                end
                cyc(r, we, st, sp, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
            end
        end

        idle_cyc();
        repeat (3) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
